lm_sm_sequencer: RTL and testbench

LM_SM_SEQUENCER -- requirements
Module: lm_sm_sequencer

---
 rtl/lm_sm_sequencer.sv | 128 ++++++++++++
 tb/tb_lm_sm_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
//   Expands LM/SM (load/store multiple) instructions into one beat per
//   register named in the 8-bit register list. All other instructions pass
//   through as a single beat. While a multi-beat sequence is in flight,
//   fetch_stall holds the PC and the IF/ID register.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   inst_in           : instruction from IF/ID ([15:12] opcode, [7:0] reg list)
//   inst_valid        : qualifies inst_in
//   stall_in          : downstream hazard stall, freezes all state
//   flush             : squashes the current and pending beats (beats stall_in)
//   inst_out          : registered instruction for the decoder/controller
//   out_valid         : qualifies inst_out
//   reg_sel, addr_off : register index and memory word offset of this beat
//   first_beat        : first beat of an instruction
//   last_beat         : final beat of an instruction
//   fetch_stall       : high while further beats remain (state == SEQ)
module lm_sm_sequencer #(
    parameter logic [3:0] OPC_LM = 4'b0110,
    parameter logic [3:0] OPC_SM = 4'b0111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] inst_in,
    input  logic        inst_valid,
    input  logic        stall_in,
    input  logic        flush,
    output logic [15:0] inst_out,
    output logic        out_valid,
    output logic [2:0]  reg_sel,
    output logic [2:0]  addr_off,
    output logic        first_beat,
    output logic        last_beat,
    output logic        fetch_stall
);
    typedef enum logic {IDLE = 1'b0, SEQ = 1'b1} state_t;

    state_t      state;
    logic [7:0]  rem;       // registers still to be emitted
    logic [15:0] lat_inst;  // instruction being expanded

    // Index of the lowest set bit; the scan runs high-to-low so the
    // lowest set bit is the last one to win.
    function automatic logic [2:0] low_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) idx = 3'(i);
        return idx;
    endfunction

    logic [7:0] list;
    logic       is_lmsm;
    logic [7:0] list_rest;  // list with its lowest set bit cleared
    logic [7:0] rem_rest;   // rem with its lowest set bit cleared

    assign list      = inst_in[7:0];
    assign is_lmsm   = (inst_in[15:12] == OPC_LM) || (inst_in[15:12] == OPC_SM);
    assign list_rest = list & (list - 8'd1);
    assign rem_rest  = rem & (rem - 8'd1);

    assign fetch_stall = (state == SEQ);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rem        <= 8'h00;
            lat_inst   <= 16'h0000;
            inst_out   <= 16'h0000;
            out_valid  <= 1'b0;
            reg_sel    <= 3'd0;
            addr_off   <= 3'd0;
            first_beat <= 1'b0;
            last_beat  <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            rem        <= 8'h00;
            inst_out   <= 16'h0000;
            out_valid  <= 1'b0;
            reg_sel    <= 3'd0;
            addr_off   <= 3'd0;
            first_beat <= 1'b0;
            last_beat  <= 1'b0;
        end else if (!stall_in) begin
            // Bubble unless a beat is produced below.
            inst_out   <= 16'h0000;
            out_valid  <= 1'b0;
            reg_sel    <= 3'd0;
            addr_off   <= 3'd0;
            first_beat <= 1'b0;
            last_beat  <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid) begin
                        if (!is_lmsm) begin
                            inst_out   <= inst_in;
                            out_valid  <= 1'b1;
                            first_beat <= 1'b1;
                            last_beat  <= 1'b1;
                        end else if (list != 8'h00) begin
                            inst_out   <= inst_in;
                            out_valid  <= 1'b1;
                            reg_sel    <= low_idx(list);
                            first_beat <= 1'b1;
                            last_beat  <= (list_rest == 8'h00);
                            rem        <= list_rest;
                            lat_inst   <= inst_in;
                            state      <= (list_rest != 8'h00) ? SEQ : IDLE;
                        end
                        // An empty list leaves the bubble in place.
                    end
                end
                SEQ: begin
                    inst_out  <= lat_inst;
                    out_valid <= 1'b1;
                    reg_sel   <= low_idx(rem);
                    // At most 8 beats, so the offset tops out at 7.
                    addr_off  <= addr_off + 3'd1;
                    last_beat <= (rem_rest == 8'h00);
                    rem       <= rem_rest;
                    if (rem_rest == 8'h00) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;
    localparam logic [3:0] OPC_LM = 4'b0110;
    localparam logic [3:0] OPC_SM = 4'b0111;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst_in;
    logic        inst_valid, stall_in, flush;
    logic [15:0] inst_out;
    logic        out_valid, first_beat, last_beat, fetch_stall;
    logic [2:0]  reg_sel, addr_off;

    lm_sm_sequencer #(.OPC_LM(OPC_LM), .OPC_SM(OPC_SM)) dut (
        .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid),
        .stall_in(stall_in), .flush(flush), .inst_out(inst_out),
        .out_valid(out_valid), .reg_sel(reg_sel), .addr_off(addr_off),
        .first_beat(first_beat), .last_beat(last_beat), .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 0;

    // Model: the current output beat plus a queue of beats still owed.
    typedef struct {
        logic [15:0] inst;
        logic        v;
        logic [2:0]  rs;
        logic [2:0]  ao;
        logic        fb;
        logic        lb;
    } beat_t;

    beat_t m_cur;
    beat_t pend[$];

    function automatic beat_t bubble();
        beat_t b;
        b.inst = 16'h0000; b.v = 1'b0; b.rs = 3'd0; b.ao = 3'd0; b.fb = 1'b0; b.lb = 1'b0;
        return b;
    endfunction

    function automatic logic [25:0] pack(input logic [15:0] i, input logic v, input logic [2:0] rs,
                                         input logic [2:0] ao, input logic fb, input logic lb,
                                         input logic fs);
        return {i, v, rs, ao, fb, lb, fs};
    endfunction

    logic [25:0] dut_vec;
    assign dut_vec = {inst_out, out_valid, reg_sel, addr_off, first_beat, last_beat, fetch_stall};

    task automatic model_reset();
        m_cur = bubble();
        pend.delete();
    endtask

    // Applies one clock edge to the model using the inputs held across it.
    task automatic model_edge();
        beat_t beats[$];
        beat_t b;
        int n, k;
        if (rst) model_reset();
        else if (flush) model_reset();
        else if (stall_in) begin end
        else if (pend.size() != 0) m_cur = pend.pop_front();
        else if (inst_valid) begin
            if (inst_in[15:12] == OPC_LM || inst_in[15:12] == OPC_SM) begin
                n = $countones(inst_in[7:0]);
                k = 0;
                for (int i = 0; i < 8; i++) begin
                    if (inst_in[i]) begin
                        b.inst = inst_in; b.v = 1'b1; b.rs = 3'(i); b.ao = 3'(k);
                        b.fb = (k == 0); b.lb = (k == n - 1);
                        beats.push_back(b);
                        k++;
                    end
                end
                if (n == 0) m_cur = bubble();
                else begin
                    m_cur = beats.pop_front();
                    pend = beats;
                end
            end else begin
                b.inst = inst_in; b.v = 1'b1; b.rs = 3'd0; b.ao = 3'd0; b.fb = 1'b1; b.lb = 1'b1;
                m_cur = b;
            end
        end else m_cur = bubble();
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        logic [25:0] exp;
        if (chk_en) begin
            exp = pack(m_cur.inst, m_cur.v, m_cur.rs, m_cur.ao, m_cur.fb, m_cur.lb, pend.size() != 0);
            vectors++;
            if (dut_vec !== exp) begin
                miscompares++;
                $display("FAIL model_cmp t=%0t: got %h expected %h", $time, dut_vec, exp);
            end
        end
    end

    task automatic pin(input string name, input logic [25:0] exp);
        vectors++;
        if (dut_vec !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, dut_vec, exp);
        end
    endtask

    // Drive inputs, take one edge, return 2 time units after it.
    task automatic step(input logic v, input logic [15:0] i, input logic s, input logic f);
        inst_valid = v; inst_in = i; stall_in = s; flush = f;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    localparam logic [25:0] BUB = 26'h0;

    initial begin
        rst = 1'b1; inst_in = 16'h0; inst_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        pin("reset_state", BUB);
        chk_en = 1;
        rst = 1'b0;

        // LM 6025: registers 0,2,5
        step(1, 16'h6025, 0, 0); pin("lm6025_b0", pack(16'h6025, 1, 3'd0, 3'd0, 1, 0, 1));
        step(0, 16'h0000, 0, 0); pin("lm6025_b1", pack(16'h6025, 1, 3'd2, 3'd1, 0, 0, 1));
        step(0, 16'h0000, 0, 0); pin("lm6025_b2", pack(16'h6025, 1, 3'd5, 3'd2, 0, 1, 0));

        // SM 70FF: eight beats, offsets 0..7
        step(1, 16'h70FF, 0, 0);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) step(0, 16'h0000, 0, 0);
            pin("sm70ff_beat", pack(16'h70FF, 1, 3'(k), 3'(k), k == 0, k == 7, k != 7));
        end
        step(0, 16'h0000, 0, 0); pin("idle_bubble", BUB);

        // Pass-through and empty-list bubble
        step(1, 16'h0A50, 0, 0); pin("add_pass", pack(16'h0A50, 1, 3'd0, 3'd0, 1, 1, 0));
        step(1, 16'h6000, 0, 0); pin("lm_empty", BUB);
        step(1, 16'h0000, 0, 0); pin("opc0_pass", pack(16'h0000, 1, 3'd0, 3'd0, 1, 1, 0));

        // LM 6081 with 2 stall cycles after beat 0
        step(1, 16'h6081, 0, 0); pin("lm6081_b0", pack(16'h6081, 1, 3'd0, 3'd0, 1, 0, 1));
        step(1, 16'h0A50, 1, 0); pin("lm6081_hold1", pack(16'h6081, 1, 3'd0, 3'd0, 1, 0, 1));
        step(1, 16'h0A50, 1, 0); pin("lm6081_hold2", pack(16'h6081, 1, 3'd0, 3'd0, 1, 0, 1));
        step(1, 16'h0A50, 0, 0); pin("lm6081_b1", pack(16'h6081, 1, 3'd7, 3'd1, 0, 1, 0));

        // LM 600F flushed on beat 1 (with stall also high)
        step(1, 16'h600F, 0, 0);
        step(0, 16'h0000, 0, 0); pin("lm600f_b1", pack(16'h600F, 1, 3'd1, 3'd1, 0, 0, 1));
        step(0, 16'h0000, 1, 1); pin("flush_bubble", BUB);
        step(1, 16'h0A50, 0, 0); pin("after_flush", pack(16'h0A50, 1, 3'd0, 3'd0, 1, 1, 0));

        // Asynchronous reset mid-sequence
        step(1, 16'h60F0, 0, 0); pin("lm60f0_b0", pack(16'h60F0, 1, 3'd4, 3'd0, 1, 0, 1));
        #1 rst = 1'b1; model_reset();
        #1 pin("async_rst", BUB);
        @(posedge clk); model_edge(); #2;
        rst = 1'b0;
        step(1, 16'h1234, 0, 0); pin("adi_after_rst", pack(16'h1234, 1, 3'd0, 3'd0, 1, 1, 0));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] ins;
            logic [3:0]  op;
            case ($urandom_range(3, 0))
                0: op = OPC_LM;
                1: op = OPC_SM;
                2: op = 4'h0;
                default: op = 4'($urandom);
            endcase
            ins = {op, 12'($urandom)};
            if ($urandom_range(7, 0) == 0) ins[7:0] = 8'h00;
            if ($urandom_range(99, 0) == 0) begin
                rst = 1'b1; model_reset();
            end else rst = 1'b0;
            step($urandom_range(9, 0) < 7, ins, $urandom_range(4, 0) == 0,
                 $urandom_range(19, 0) == 0);
        end
        rst = 1'b0;
        step(0, 16'h0000, 0, 1);
        step(0, 16'h0000, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
